// File: rtl/fsram_dp_bank.sv
// Dual-port feature SRAM: SRAM_NUM independent DEPTH x DATA_W banks behind two synchronous ports.
// Read latency 1 cycle, registered Q; no backpressure, every enabled access completes on its edge.
module fsram_dp_bank #(
    parameter int SRAM_NUM = 8,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         CENA,
    input  logic                         CENB,
    input  logic [SRAM_NUM-1:0]          WENA,
    input  logic [SRAM_NUM-1:0]          WENB,
    input  logic [SRAM_NUM*ADDR_W-1:0]   AA,
    input  logic [SRAM_NUM*ADDR_W-1:0]   AB,
    input  logic [SRAM_NUM*DATA_W-1:0]   DA,
    input  logic [SRAM_NUM*DATA_W-1:0]   DB,
    output logic [SRAM_NUM*DATA_W-1:0]   QA,
    output logic [SRAM_NUM*DATA_W-1:0]   QB
);

    for (genvar i = 0; i < SRAM_NUM; i++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] qa_q;
        logic [DATA_W-1:0] qb_q;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
        logic              wr_a;
        logic              wr_b;
        logic              rd_a;
        logic              rd_b;

        assign addr_a = AA[i*ADDR_W +: ADDR_W];
        assign addr_b = AB[i*ADDR_W +: ADDR_W];
        assign wr_a   = !CENA && !WENA[i];
        assign wr_b   = !CENB && !WENB[i];
        assign rd_a   = !CENA &&  WENA[i];
        assign rd_b   = !CENB &&  WENB[i];

        // Port B's write is issued first so a same-address port A write overrides it;
        // reads sample the array before either write lands (read-before-write).
        always_ff @(posedge clk) begin
            if (rst) begin
                qa_q <= '0;
                qb_q <= '0;
            end else begin
                if (wr_b) mem[addr_b] <= DB[i*DATA_W +: DATA_W];
                if (wr_a) mem[addr_a] <= DA[i*DATA_W +: DATA_W];
                if (rd_a) qa_q <= mem[addr_a];
                if (rd_b) qb_q <= mem[addr_b];
            end
        end

        assign QA[i*DATA_W +: DATA_W] = qa_q;
        assign QB[i*DATA_W +: DATA_W] = qb_q;
    end

endmodule

// File: tb/tb_fsram_dp_bank.sv
// Directed bench for fsram_dp_bank: driver pushes expected Q per edge, negedge monitor pops and compares.
module tb_fsram_dp_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic         CENA, CENB;
    logic [7:0]   WENA, WENB;
    logic [95:0]  AA, AB;
    logic [127:0] DA, DB;
    logic [127:0] QA, QB;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0]   ma;
        logic [127:0] ea;
        logic [7:0]   mb;
        logic [127:0] eb;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    fsram_dp_bank dut (
        .clk (clk),
        .rst (rst),
        .CENA(CENA),
        .CENB(CENB),
        .WENA(WENA),
        .WENB(WENB),
        .AA  (AA),
        .AB  (AB),
        .DA  (DA),
        .DB  (DB),
        .QA  (QA),
        .QB  (QB)
    );

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    function automatic logic [95:0] aall(input logic [11:0] a);
        return {8{a}};
    endfunction

    function automatic logic [15:0] pair(input int k);
        logic [7:0] hi, lo;
        hi = 8'(k * 3 + 1);
        lo = 8'(k * 3 + 4);
        return {hi, lo};
    endfunction

    task automatic idle();
        rst  = 1'b0;
        CENA = 1'b1;
        CENB = 1'b1;
        WENA = 8'hFF;
        WENB = 8'hFF;
    endtask

    // One clock edge with the current inputs; queue the Q values expected after it.
    task automatic step(input logic [7:0] ma, input logic [127:0] ea,
                        input logic [7:0] mb, input logic [127:0] eb, input string nm);
        exp_t e;
        @(posedge clk);
        e.ma = ma; e.ea = ea; e.mb = mb; e.eb = eb;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            for (int i = 0; i < 8; i++) begin
                if (e.ma[i]) begin
                    n_chk++;
                    if (QA[i*16 +: 16] !== e.ea[i*16 +: 16]) begin
                        n_fail++;
                        $display("FAIL %s QA bank%0d got %h expected %h", nm, i, QA[i*16 +: 16], e.ea[i*16 +: 16]);
                    end
                end
                if (e.mb[i]) begin
                    n_chk++;
                    if (QB[i*16 +: 16] !== e.eb[i*16 +: 16]) begin
                        n_fail++;
                        $display("FAIL %s QB bank%0d got %h expected %h", nm, i, QB[i*16 +: 16], e.eb[i*16 +: 16]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        AA = '0; AB = '0; DA = '0; DB = '0;

        // Reset and array retention
        rst = 1'b1;
        step(8'hFF, '0, 8'hFF, '0, "reset_init");
        rst = 1'b0; CENA = 1'b0; WENA = 8'h00; AA = aall(12'h005); DA = rep(16'h1234);
        step(8'hFF, '0, 8'hFF, '0, "preload_hold");
        WENA = 8'hFF;
        step(8'hFF, rep(16'h1234), 8'hFF, '0, "preload_read");
        rst = 1'b1; CENB = 1'b0; WENB = 8'h00; AB = aall(12'h005); DB = rep(16'hDEAD);
        step(8'hFF, '0, 8'hFF, '0, "reset_mid");
        idle(); CENB = 1'b0; AB = aall(12'h005);
        step(8'hFF, '0, 8'hFF, rep(16'h1234), "retained");

        // Write then read on the other port one cycle later
        idle(); CENA = 1'b0; WENA = 8'h00; AA = aall(12'h010); DA = rep(16'hABCD);
        step(8'hFF, '0, 8'hFF, rep(16'h1234), "write_qa_hold");
        idle(); CENB = 1'b0; AB = aall(12'h010);
        step(8'hFF, '0, 8'hFF, rep(16'hABCD), "write_readback");

        // Per-bank write mask: bank0 writes, banks 1-7 read
        idle(); CENB = 1'b0; WENB = 8'h00; AB = aall(12'h020); DB = rep(16'h0F0F);
        step(8'h00, '0, 8'hFF, rep(16'hABCD), "mask_preload");
        idle(); CENA = 1'b0; WENA = 8'hFE; AA = aall(12'h020); DA = rep(16'h5A5A);
        step(8'hFF, {{7{16'h0F0F}}, 16'h0000}, 8'h00, '0, "mask_mixed");
        idle(); CENB = 1'b0; AB = aall(12'h020);
        step(8'h00, '0, 8'hFF, {{7{16'h0F0F}}, 16'h5A5A}, "mask_readback");

        // Port B disabled: toggling its inputs must change nothing
        for (int c = 0; c < 3; c++) begin
            idle(); WENB = 8'(c * 37); AB = aall(12'(12'h010 + c * 16)); DB = rep(16'(16'hDEAD + c));
            step(8'h00, '0, 8'hFF, {{7{16'h0F0F}}, 16'h5A5A}, "cenb_hold");
        end
        idle(); CENA = 1'b0; AA = aall(12'h010);
        step(8'hFF, rep(16'hABCD), 8'h00, '0, "cenb_mem_kept");

        // Collisions at 0x100
        idle(); CENA = 1'b0; WENA = 8'h00; AA = aall(12'h100); DA = rep(16'h1111);
        step(8'hFF, rep(16'hABCD), 8'h00, '0, "col_preload");
        DA = rep(16'h2222); CENB = 1'b0; AB = aall(12'h100);
        step(8'hFF, rep(16'hABCD), 8'hFF, rep(16'h1111), "col_rbw");
        WENA = 8'hFF;
        step(8'hFF, rep(16'h2222), 8'hFF, rep(16'h2222), "col_both_read");
        WENA = 8'h00; WENB = 8'h00; DA = rep(16'h3333); DB = rep(16'h4444);
        step(8'hFF, rep(16'h2222), 8'hFF, rep(16'h2222), "col_ww_hold");
        idle(); CENB = 1'b0; AB = aall(12'h100);
        step(8'h00, '0, 8'hFF, rep(16'h3333), "col_ww_a_wins");
        WENB = 8'h00; DB = rep(16'h5555); CENA = 1'b0; AA = aall(12'h100);
        step(8'hFF, rep(16'h3333), 8'hFF, rep(16'h3333), "col_rbw_b");
        idle(); CENA = 1'b0; AA = aall(12'h100);
        step(8'hFF, rep(16'h5555), 8'h00, '0, "col_b_write");

        // Feature-pair streaming across the 0xFFF -> 0x000 wrap, port B one cycle behind
        for (int k = 0; k <= 256; k++) begin
            idle();
            if (k < 256) begin
                CENA = 1'b0; WENA = 8'h00;
                AA = aall(12'(12'hF80 + k)); DA = rep(pair(k));
            end
            if (k >= 1) begin
                CENB = 1'b0;
                AB = aall(12'(12'hF80 + k - 1));
            end
            step(8'h00, '0, (k >= 1) ? 8'hFF : 8'h00, rep(pair(k - 1)), "stream");
        end

        idle();
        repeat (2) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain queue got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
